// File: rtl/sysid_check_ctrl.sv
// ============================================================================
// sysid_check_ctrl : Avalon-MM read master that verifies sysid ID/timestamp
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID    = 32'h00000000,
  parameter logic [31:0] EXPECTED_TS    = 32'h5121D75E,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          MAX_RETRIES    = 2,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout_err,
  output logic [2:0]  retry_count,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD_ID  = 3'd1;
  localparam logic [2:0] LAT_ID = 3'd2;
  localparam logic [2:0] RD_TS  = 3'd3;
  localparam logic [2:0] LAT_TS = 3'd4;
  localparam logic [2:0] CHECK  = 3'd5;
  localparam logic [2:0] FINISH = 3'd6;

  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] LAT_LAST  = 2'(READ_LATENCY - 1);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRIES);
  localparam bit         USE_LAT   = (READ_LATENCY != 0);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [7:0] tcnt;
  logic [1:0] lcnt;
  logic       auto_pend;

  logic accept;
  logic in_read;
  logic in_lat;
  logic cap_id;
  logic cap_ts;
  logic tmo;
  logic match;
  logic retry_ok;
  logic launch;

  assign m_read    = (state == RD_ID) || (state == RD_TS);
  assign m_address = (state == RD_TS) || (state == LAT_TS);
  assign busy      = (state != IDLE) && (state != FINISH);
  assign done      = (state == FINISH);

  assign accept   = m_read && !m_waitrequest;
  assign in_lat   = (state == LAT_ID) || (state == LAT_TS);
  assign in_read  = m_read || in_lat;
  assign cap_id   = ((state == RD_ID) && accept && !USE_LAT) ||
                    ((state == LAT_ID) && (lcnt == LAT_LAST));
  assign cap_ts   = ((state == RD_TS) && accept && !USE_LAT) ||
                    ((state == LAT_TS) && (lcnt == LAT_LAST));
  // A capture landing on the final allowed cycle beats the timeout.
  assign tmo      = in_read && !cap_id && !cap_ts && (tcnt == TO_LAST);
  assign match    = (captured_id == EXPECTED_ID) && (captured_ts == EXPECTED_TS);
  assign retry_ok = (retry_count < RETRY_MAX);
  assign launch   = (state == IDLE) && (start || auto_pend);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (launch) state_nxt = RD_ID;
      end
      RD_ID: begin
        if (tmo)         state_nxt = FINISH;
        else if (accept) state_nxt = USE_LAT ? LAT_ID : RD_TS;
      end
      LAT_ID: begin
        if (tmo)         state_nxt = FINISH;
        else if (cap_id) state_nxt = RD_TS;
      end
      RD_TS: begin
        if (tmo)         state_nxt = FINISH;
        else if (accept) state_nxt = USE_LAT ? LAT_TS : CHECK;
      end
      LAT_TS: begin
        if (tmo)         state_nxt = FINISH;
        else if (cap_ts) state_nxt = CHECK;
      end
      CHECK: begin
        if (match)         state_nxt = FINISH;
        else if (retry_ok) state_nxt = RD_ID;
        else               state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      auto_pend <= AUTO_START;
    end else begin
      state     <= state_nxt;
      auto_pend <= 1'b0;
    end
  end

  // Per-read timeout counter restarts whenever a new read is launched.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tcnt <= 8'd0;
    end else if (((state_nxt == RD_ID) || (state_nxt == RD_TS)) && (state_nxt != state)) begin
      tcnt <= 8'd0;
    end else if (in_read && (tcnt != 8'hFF)) begin
      tcnt <= tcnt + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lcnt <= 2'd0;
    end else if (!in_lat) begin
      lcnt <= 2'd0;
    end else if (lcnt != 2'b11) begin
      lcnt <= lcnt + 2'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pass        <= 1'b0;
      timeout_err <= 1'b0;
      retry_count <= 3'd0;
      captured_id <= 32'd0;
      captured_ts <= 32'd0;
    end else begin
      if (launch) begin
        pass        <= 1'b0;
        timeout_err <= 1'b0;
        retry_count <= 3'd0;
      end
      if (cap_id) captured_id <= m_readdata;
      if (cap_ts) captured_ts <= m_readdata;
      if (tmo) begin
        timeout_err <= 1'b1;
        pass        <= 1'b0;
      end
      if (state == CHECK) begin
        if (match)         pass        <= 1'b1;
        else if (retry_ok) retry_count <= retry_count + 3'd1;
        else               pass        <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sysid_check_ctrl.sv
// ============================================================================
// tb_sysid_check_ctrl : scoreboard bench for two sysid_check_ctrl configs
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sysid_check_ctrl;

  localparam logic [31:0] TS = 32'h5121D75E;

  typedef struct {
    logic        pass;
    logic        tmo;
    logic [2:0]  retry;
    logic [31:0] cid;
    logic [31:0] cts;
    int          nacc;
    int          nrd;
    int          lat;
    int          base_acc;
    int          base_rd;
    int          st_cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea;
  exp_t eb;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  logic        addr_a, rd_a, wr_a, busy_a, done_a, pass_a, tmo_a;
  logic [31:0] rdata_a, cid_a, cts_a;
  logic [2:0]  retry_a;
  logic        addr_b, rd_b, wr_b, busy_b, done_b, pass_b, tmo_b;
  logic [31:0] rdata_b, cid_b, cts_b;
  logic [2:0]  retry_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int ws_cfg_a = 0;
  int ws_cnt_a = 0;
  int bad_n_a  = 0;
  int id_base_a = 0;
  int id_acc_a = 0;
  int acc_a = 0;
  int rdc_a = 0;
  logic stuck_b = 1'b0;
  int acc_b = 0;
  int rdc_b = 0;
  logic v1 = 1'b0, v2 = 1'b0, a1 = 1'b0, a2 = 1'b0;
  logic prev_stall_a = 1'b0;
  logic prev_addr_a  = 1'b0;

  always #5 clock = ~clock;

  sysid_check_ctrl dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a),
    .m_address(addr_a), .m_read(rd_a), .m_readdata(rdata_a), .m_waitrequest(wr_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .timeout_err(tmo_a),
    .retry_count(retry_a), .captured_id(cid_a), .captured_ts(cts_a)
  );

  sysid_check_ctrl #(
    .READ_LATENCY(2), .TIMEOUT_CYCLES(8), .MAX_RETRIES(1), .AUTO_START(1'b0)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b),
    .m_address(addr_b), .m_read(rd_b), .m_readdata(rdata_b), .m_waitrequest(wr_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .timeout_err(tmo_b),
    .retry_count(retry_b), .captured_id(cid_b), .captured_ts(cts_b)
  );

  // Slave A: zero-latency, programmable wait states, ID wrong for the first bad_n_a ID reads.
  assign wr_a    = rd_a && (ws_cnt_a < ws_cfg_a);
  assign rdata_a = addr_a ? TS : (((id_acc_a - id_base_a) < bad_n_a) ? 32'h1 : 32'h0);

  // Slave B: data valid exactly two cycles after acceptance, garbage otherwise.
  assign wr_b    = rd_b && stuck_b;
  assign rdata_b = v2 ? (a2 ? TS : 32'h0) : 32'hDEADBEEF;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (rd_a && wr_a) ws_cnt_a <= ws_cnt_a + 1;
    else              ws_cnt_a <= 0;
    if (rd_a && !wr_a) begin
      acc_a <= acc_a + 1;
      if (!addr_a) id_acc_a <= id_acc_a + 1;
    end
    if (rd_a) rdc_a <= rdc_a + 1;
    v1 <= rd_b && !wr_b;
    a1 <= addr_b;
    v2 <= v1;
    a2 <= a1;
    if (rd_b && !wr_b) acc_b <= acc_b + 1;
    if (rd_b) rdc_b <= rdc_b + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (done_a) begin
        if (q_a.size() == 0) begin
          chk("a_extra_done", 1, 0);
        end else begin
          ea = q_a.pop_front();
          chk("a_pass", pass_a, ea.pass);
          chk("a_tmo", tmo_a, ea.tmo);
          chk("a_retry", retry_a, ea.retry);
          chk("a_cid", cid_a, ea.cid);
          chk("a_cts", cts_a, ea.cts);
          chk("a_reads", acc_a - ea.base_acc, ea.nacc);
          chk("a_rdcyc", rdc_a - ea.base_rd, ea.nrd);
          if (ea.lat >= 0) chk("a_lat", cyc - ea.st_cyc, ea.lat);
        end
      end
      if (done_b) begin
        if (q_b.size() == 0) begin
          chk("b_extra_done", 1, 0);
        end else begin
          eb = q_b.pop_front();
          chk("b_pass", pass_b, eb.pass);
          chk("b_tmo", tmo_b, eb.tmo);
          chk("b_retry", retry_b, eb.retry);
          chk("b_cid", cid_b, eb.cid);
          chk("b_cts", cts_b, eb.cts);
          chk("b_reads", acc_b - eb.base_acc, eb.nacc);
          chk("b_rdcyc", rdc_b - eb.base_rd, eb.nrd);
          if (eb.lat >= 0) chk("b_lat", cyc - eb.st_cyc, eb.lat);
        end
      end
      if (prev_stall_a) begin
        chk("a_rd_hold", rd_a, 1);
        chk("a_addr_hold", addr_a, prev_addr_a);
      end
      if (v1 || v2) chk("b_rd_in_lat", rd_b, 0);
      prev_stall_a <= rd_a && wr_a;
      prev_addr_a  <= addr_a;
    end else begin
      prev_stall_a <= 1'b0;
    end
  end

  function automatic exp_t mk(input bit sel, input logic p, input logic t, input logic [2:0] r,
                              input logic [31:0] cid, input logic [31:0] cts,
                              input int nacc, input int nrd, input int lat);
    exp_t e;
    e.pass = p; e.tmo = t; e.retry = r; e.cid = cid; e.cts = cts;
    e.nacc = nacc; e.nrd = nrd; e.lat = lat;
    e.base_acc = sel ? acc_b : acc_a;
    e.base_rd  = sel ? rdc_b : rdc_a;
    e.st_cyc   = cyc;
    return e;
  endfunction

  // Pulse start, then queue the expectation stamped at the sampling edge.
  task automatic issue(input bit sel, input logic p, input logic t, input logic [2:0] r,
                       input logic [31:0] cid, input logic [31:0] cts,
                       input int nacc, input int nrd, input int lat);
    @(posedge clock); #1;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    if (sel) q_b.push_back(mk(1'b1, p, t, r, cid, cts, nacc, nrd, lat));
    else     q_a.push_back(mk(1'b0, p, t, r, cid, cts, nacc, nrd, lat));
  endtask

  task automatic wait_q(input bit sel, input int max);
    for (int i = 0; i < max; i++) begin
      @(posedge clock);
      if ((sel ? q_b.size() : q_a.size()) == 0) break;
    end
    #1;
    if ((sel ? q_b.size() : q_a.size()) != 0) begin
      chk(sel ? "b_wait_done" : "a_wait_done", 0, 1);
      if (sel) q_b.delete(); else q_a.delete();
    end
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_tmo", tmo_a, 0);
    chk("rst_retry", retry_a, 0);
    chk("rst_read", rd_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_cid", cid_a, 0);
    chk("rst_cts", cts_a, 0);
    chk("rst_busy_b", busy_b, 0);

    q_a.push_back(mk(1'b0, 1'b1, 1'b0, 3'd0, 32'h0, TS, 2, 2, -1));
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("a_autostart_rd", rd_a, 1);
    chk("b_no_autostart", busy_b, 0);
    wait_q(1'b0, 50);

    // Plain check; then a start pulse during FINISH must be dropped.
    issue(1'b0, 1'b1, 1'b0, 3'd0, 32'h0, TS, 2, 2, 3);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (done_a) begin seen = 1'b1; break; end
    end
    chk("a_done_seen", seen, 1);
    start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    @(posedge clock); #1;
    chk("a_finish_start_ignored", busy_a, 0);
    wait_q(1'b0, 5);

    // Four wait states per read, with an extra start while busy.
    ws_cfg_a = 4;
    issue(1'b0, 1'b1, 1'b0, 3'd0, 32'h0, TS, 2, 10, 11);
    repeat (3) @(posedge clock);
    #1 start_a = 1'b1;
    @(posedge clock); #1 start_a = 1'b0;
    wait_q(1'b0, 50);
    repeat (4) @(posedge clock);
    #1 ws_cfg_a = 0;

    // Two bad ID sequences, then good.
    id_base_a = id_acc_a;
    bad_n_a = 2;
    issue(1'b0, 1'b1, 1'b0, 3'd2, 32'h0, TS, 6, 6, 9);
    wait_q(1'b0, 50);

    // Always-bad ID: retries exhausted.
    id_base_a = id_acc_a;
    bad_n_a = 1000;
    issue(1'b0, 1'b0, 1'b0, 3'd2, 32'h1, TS, 6, 6, 9);
    wait_q(1'b0, 50);
    bad_n_a = 0;

    // Latency-2 reads on B.
    issue(1'b1, 1'b1, 1'b0, 3'd0, 32'h0, TS, 2, 2, 7);
    wait_q(1'b1, 50);

    // Stuck waitrequest on B: timeout after 8 cycles, no timestamp read.
    stuck_b = 1'b1;
    issue(1'b1, 1'b0, 1'b1, 3'd0, 32'h0, TS, 0, 8, 8);
    wait_q(1'b1, 50);
    stuck_b = 1'b0;
    repeat (2) @(posedge clock);

    // Reset during the timestamp read, then automatic restart.
    @(posedge clock); #1 start_a = 1'b1;
    @(posedge clock); #1 start_a = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rd_a && addr_a) begin seen = 1'b1; break; end
      @(posedge clock); #1;
    end
    chk("a_rdts_reached", seen, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("a_midrst_read", rd_a, 0);
    chk("a_midrst_busy", busy_a, 0);
    chk("a_midrst_done", done_a, 0);
    repeat (2) @(posedge clock);
    #1;
    q_a.push_back(mk(1'b0, 1'b1, 1'b0, 3'd0, 32'h0, TS, 2, 2, -1));
    reset_n = 1'b1;
    wait_q(1'b0, 50);

    repeat (5) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
